// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - code entry, settle, check, open and lockout sequencer for encrypted_lock
module lock_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int OPEN_CYCLES    = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] code_in,
    input  logic       enter,
    input  logic       relock,
    output logic [5:0] lock_code,
    input  logic       lock_z,
    output logic       unlocked,
    output logic       alarm,
    output logic       busy,
    output logic       fail_pulse,
    output logic [3:0] attempts_left
);

    localparam int MAX_SO = (SETTLE_CYCLES > OPEN_CYCLES) ? SETTLE_CYCLES : OPEN_CYCLES;
    localparam int MAX_T  = (MAX_SO > LOCKOUT_CYCLES) ? MAX_SO : LOCKOUT_CYCLES;
    localparam int TW     = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    MAX_FAIL_W   = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic [3:0]    fail_cnt;
    logic [3:0]    fail_cnt_inc;

    // Failure count never wraps: it stops at the limit.
    assign fail_cnt_inc = (fail_cnt >= MAX_FAIL_W) ? MAX_FAIL_W : fail_cnt + 4'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; lock_z only matters in the single CHECK cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (enter) begin
                    next_state = S_APPLY;
                end
            end
            S_APPLY: begin
                if (timer == SETTLE_LAST) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (lock_z) begin
                    next_state = S_OPEN;
                end else if (fail_cnt_inc == MAX_FAIL_W) begin
                    next_state = S_LOCKOUT;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_OPEN: begin
                if (relock || timer == OPEN_LAST) begin
                    next_state = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer == LOCKOUT_LAST) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers: phase timer, latched code, failure count, reject pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= '0;
            lock_code  <= 6'd0;
            fail_cnt   <= 4'd0;
            fail_pulse <= 1'b0;
        end else begin
            // Timer restarts on every state change so each phase counts from zero.
            if (state == S_IDLE || next_state != state) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if (state == S_IDLE && enter) begin
                lock_code <= code_in;
            end else if (next_state == S_IDLE) begin
                lock_code <= 6'd0;
            end

            if (state == S_CHECK) begin
                fail_cnt <= lock_z ? 4'd0 : fail_cnt_inc;
            end else if (state == S_LOCKOUT && next_state == S_IDLE) begin
                fail_cnt <= 4'd0;
            end

            fail_pulse <= (state == S_CHECK) && !lock_z;
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        unlocked      = (state == S_OPEN);
        alarm         = (state == S_LOCKOUT);
        busy          = (state != S_IDLE);
        attempts_left = (state == S_LOCKOUT) ? 4'd0 : MAX_FAIL_W - fail_cnt;
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - self-checking bench for lock_sequencer
module tb_lock_sequencer;

    localparam logic [5:0] GOOD = 6'b010101;

    logic       clk;
    logic       rst;
    logic [5:0] code_in;
    logic       enter;
    logic       relock;
    logic [5:0] lock_code;
    logic       lock_z;
    logic       unlocked;
    logic       alarm;
    logic       busy;
    logic       fail_pulse;
    logic [3:0] attempts_left;
    logic       z_force;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0] code;
        logic       exp_unl;
        logic [3:0] exp_att;
    } vec_t;

    typedef struct {
        logic       unl;
        logic [3:0] att;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];

    lock_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .code_in      (code_in),
        .enter        (enter),
        .relock       (relock),
        .lock_code    (lock_code),
        .lock_z       (lock_z),
        .unlocked     (unlocked),
        .alarm        (alarm),
        .busy         (busy),
        .fail_pulse   (fail_pulse),
        .attempts_left(attempts_left)
    );

    // Lock model, with an override to inject a glitch on z.
    assign lock_z = z_force | (lock_code == GOOD);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Submit one code from a negedge; returns at the sample point after edge E0.
    task automatic start(input logic [5:0] c, input logic u, input logic [3:0] a);
        exp_t e;
        e.unl = u;
        e.att = a;
        sb.push_back(e);
        code_in = c;
        enter   = 1'b1;
        @(negedge clk);
        enter   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_unlocked();
        int n = 0;
        while (unlocked !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_unlocked", {31'd0, unlocked}, 32'd1);
    endtask

    // Scoreboard monitor: every resolved attempt pops one expectation.
    initial begin
        logic prev_unl;
        exp_t e;
        prev_unl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && (fail_pulse === 1'b1 || (unlocked === 1'b1 && prev_unl !== 1'b1))) begin
                chk("sb_attempt_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_unlocked", {31'd0, unlocked}, {31'd0, e.unl});
                    chk("sb_attempts_left", {28'd0, attempts_left}, {28'd0, e.att});
                end
            end
            prev_unl = unlocked;
        end
    end

    initial begin
        int n;
        vecs[0] = '{code: 6'b000000, exp_unl: 1'b0, exp_att: 4'd1};
        vecs[1] = '{code: GOOD,      exp_unl: 1'b1, exp_att: 4'd3};
        vecs[2] = '{code: 6'b111111, exp_unl: 1'b0, exp_att: 4'd2};
        vecs[3] = '{code: 6'b010100, exp_unl: 1'b0, exp_att: 4'd1};

        rst = 1'b1; enter = 1'b0; relock = 1'b0; code_in = 6'd0; z_force = 1'b0;
        #2;
        chk("rst_unlocked", {31'd0, unlocked}, 32'd0);
        chk("rst_alarm", {31'd0, alarm}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_attempts", {28'd0, attempts_left}, 32'd3);
        chk("rst_lock_code", {26'd0, lock_code}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Good code: latency and open duration.
        start(GOOD, 1'b1, 4'd3);
        chk("good_code_e0", {26'd0, lock_code}, {26'd0, GOOD});
        chk("good_busy_e0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("good_code_e1", {26'd0, lock_code}, {26'd0, GOOD});
        chk("good_unl_e1", {31'd0, unlocked}, 32'd0);
        @(negedge clk);
        chk("good_unl_e2", {31'd0, unlocked}, 32'd0);
        @(negedge clk);
        chk("good_unl_e3", {31'd0, unlocked}, 32'd1);
        n = 0;
        while (unlocked === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("good_open_cycles", n, 32'd8);
        chk("good_after_code", {26'd0, lock_code}, 32'd0);
        chk("good_after_busy", {31'd0, busy}, 32'd0);

        // Bad code: one-cycle fail pulse at E0+3; relock outside OPEN is ignored.
        relock = 1'b1;
        start(6'b101011, 1'b0, 4'd2);
        @(negedge clk);
        @(negedge clk);
        chk("bad_pulse_e2", {31'd0, fail_pulse}, 32'd0);
        @(negedge clk);
        chk("bad_pulse_e3", {31'd0, fail_pulse}, 32'd1);
        chk("bad_attempts", {28'd0, attempts_left}, 32'd2);
        chk("bad_unlocked", {31'd0, unlocked}, 32'd0);
        @(negedge clk);
        chk("bad_pulse_e4", {31'd0, fail_pulse}, 32'd0);
        chk("bad_idle", {31'd0, busy}, 32'd0);
        relock = 1'b0;

        // Table of attempts, including a match with MAX_FAIL-1 failures stored.
        for (int i = 0; i < 4; i++) begin
            start(vecs[i].code, vecs[i].exp_unl, vecs[i].exp_att);
            wait_idle();
        end

        // Third consecutive failure: lockout, good code ignored during alarm.
        start(6'b010111, 1'b0, 4'd0);
        n = 0;
        while (alarm !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lockout_attempts", {28'd0, attempts_left}, 32'd0);
        n = 0;
        while (alarm === 1'b1 && n < 100) begin
            if (n == 4) begin
                code_in = GOOD;
                enter   = 1'b1;
            end else begin
                enter   = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        enter = 1'b0;
        chk("lockout_cycles", n, 32'd16);
        chk("lockout_exit_attempts", {28'd0, attempts_left}, 32'd3);
        chk("lockout_exit_busy", {31'd0, busy}, 32'd0);
        chk("lockout_exit_code", {26'd0, lock_code}, 32'd0);

        // Two failures, then a match resets the count; relock in the 2nd open cycle.
        start(6'b100000, 1'b0, 4'd2);
        wait_idle();
        start(6'b000001, 1'b0, 4'd1);
        wait_idle();
        start(GOOD, 1'b1, 4'd3);
        wait_unlocked();
        @(negedge clk);
        chk("relock_open2", {31'd0, unlocked}, 32'd1);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        chk("relock_unlocked", {31'd0, unlocked}, 32'd0);
        chk("relock_busy", {31'd0, busy}, 32'd0);
        chk("relock_code", {26'd0, lock_code}, 32'd0);

        // z glitch high during APPLY, low in CHECK; enter pulses while busy.
        z_force = 1'b1;
        start(6'b101011, 1'b0, 4'd2);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        z_force = 1'b0;
        enter   = 1'b1;
        @(negedge clk);
        enter   = 1'b0;
        chk("settle_reject", {31'd0, fail_pulse}, 32'd1);
        chk("settle_unlocked", {31'd0, unlocked}, 32'd0);
        wait_idle();
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of OPEN.
        start(GOOD, 1'b1, 4'd3);
        wait_unlocked();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_unlocked", {31'd0, unlocked}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_fail_pulse", {31'd0, fail_pulse}, 32'd0);
        chk("arst_attempts", {28'd0, attempts_left}, 32'd3);
        chk("arst_lock_code", {26'd0, lock_code}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
